panel_command_sequencer: RTL and testbench
==========================================

# panel_command_sequencer

Front-panel command sequencer for the MACH64 CPU. It services the `wasPressed` flags from up to three debounced button detectors and returns a one-cycle `ackPress` to the detector it services. Each press becomes a single valid/ready command transfer to the CPU control unit. It sits between the panel button detectors and the CPU, and it also owns the panel's run/halt mode bit.

## Interface
- `DATA_WIDTH`, 8, width of the switch register and `cmdData`.
- `TIMEOUT_CYCLES`, 255, maximum cycles in ISSUE before abandoning a command; used only with `PANEL_TIMEOUT_EN`; range 1..65535.
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `wasPressed`  in  3  level flags from the detectors. Bit 0 = RUN/HALT, bit 1 = STEP, bit 2 = DEPOSIT.
- `switches`  in  DATA_WIDTH  panel data switches.
- `ackPress`  out  3  one-hot, one-cycle acknowledge to the serviced detector.
- `cmdValid`  out  1  command offered to the CPU.
- `cmdCode`  out  2  00 STEP, 01 RUN, 10 HALT, 11 DEPOSIT.
- `cmdData`  out  DATA_WIDTH  switch value latched for DEPOSIT; 0 for other commands.
- `cmdReady`  in  1  CPU accepts the command.
- `runMode`  out  1  1 = CPU running.
- `timeoutErr`  out  1  sticky flag: a command was abandoned.

## Operation
- Three-state FSM.
  - IDLE: if any `wasPressed` bit is high, select the lowest set index. Latch the select, the command code and `switches`, then go to ACK.
  - ACK: drive `ackPress[sel]`=1 for exactly this cycle.
    - If sel=STEP and `runMode`=1, the press is dropped: go to IDLE with no command.
    - Otherwise go to ISSUE.
  - ISSUE: hold `cmdValid`=1 with stable `cmdCode`/`cmdData` until `cmdValid&&cmdReady`, then go to IDLE.
- Command code by button:
  - RUN/HALT button: code is RUN if `runMode`=0, HALT if `runMode`=1.
  - STEP button: code STEP.
  - DEPOSIT button: code DEPOSIT, with `cmdData` = latched switches.
- `runMode` updates only on the accepting edge of a RUN (→1) or HALT (→0) transfer.
- Switch changes after the IDLE latch edge have no effect on `cmdData`.
- Other pending `wasPressed` bits are ignored until the FSM is back in IDLE. Each one is then serviced in priority order, one per pass.
- Reset values: state IDLE; `ackPress`=000, `cmdValid`=0, `cmdCode`=00, `cmdData`=0, `runMode`=0, `timeoutErr`=0.
- Reset in any state aborts any in-flight command. A detector still holding `wasPressed` after reset is serviced normally.
- Illegal state encodings return to IDLE on the next edge.

## Timing
- Edge N: IDLE samples a set `wasPressed`; state becomes ACK.
- Cycle N..N+1: `ackPress` is high. The detector samples it at edge N+1 and drops `wasPressed` after it.
- Edge N+1: state becomes ISSUE; `cmdValid` is high from N+1.
- Accepted at the first edge M ≥ N+2 where `cmdReady`=1; `cmdValid` is low after M.
- Minimum 3 cycles per command; 2 cycles for a dropped STEP.
- No re-trigger: the earliest next IDLE sample is edge N+2, after the detector has left its pressed state.
- `cmdValid` never deasserts without acceptance, except on timeout or reset.
- `ackPress` is never asserted in the same cycle as `cmdValid`.

## Configuration
- Macro: `PANEL_TIMEOUT_EN`.
- Defined:
  - A counter runs while in ISSUE.
  - After `TIMEOUT_CYCLES` cycles in ISSUE without acceptance, `cmdValid` drops, state returns to IDLE, `timeoutErr` sets, and `runMode` is unchanged.
  - `timeoutErr` clears only on reset.
  - If acceptance and timeout occur on the same edge, acceptance wins.
- Undefined: no counter; ISSUE waits indefinitely; `timeoutErr` is tied 0.

## Structure
- Shared package/include `panel_pkg`: FSM state encodings, `cmdCode` values, and button index constants (BTN_RUN=0, BTN_STEP=1, BTN_DEPOSIT=2).
- One sub-module, `panel_timeout_counter`: load/enable down-counter that outputs `expired`. Instantiated only under `PANEL_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `wasPressed`=111 → all outputs at reset values. After release, RUN is serviced first.
- **RUN:** `wasPressed`=001, `cmdReady`=1 → `ackPress`=001 for exactly 1 cycle, then `cmdValid` with `cmdCode`=01 for 1 cycle. `runMode`=1 after the accepting edge.
- **Simultaneous presses:** `wasPressed`=111, `runMode`=0, `switches`=0x5A, `cmdReady`=1 → order is RUN issued, STEP acked and dropped (no `cmdValid`), then DEPOSIT issued with `cmdData`=0x5A.
- **Data stability:** DEPOSIT with `switches`=0xA5 latched, then `switches`→0x3C with `cmdReady`=0 for 5 cycles → `cmdData` stays 0xA5 and `cmdValid` stays high until `cmdReady`.
- **Timeout:** `PANEL_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4, STEP pressed, `cmdReady`=0 → `cmdValid` high 4 cycles then low, `timeoutErr`=1 and stays 1, `runMode` unchanged.
- **Reset mid-command:** `reset` asserted during ISSUE of HALT (`runMode`=1) → `cmdValid`=0 and `runMode`=0 after the edge; no transfer is recorded.

Source files
------------

// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
//   Shared definitions for the MACH64 front-panel command sequencer:
//   FSM state encodings, command codes placed on cmdCode, button index
//   constants, and a helper that picks the highest-priority pending button.
// -----------------------------------------------------------------------------
package panel_pkg;

  localparam int NUM_BTN = 3;
  localparam int TMR_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACK   = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  localparam logic [1:0] CMD_STEP    = 2'b00;
  localparam logic [1:0] CMD_RUN     = 2'b01;
  localparam logic [1:0] CMD_HALT    = 2'b10;
  localparam logic [1:0] CMD_DEPOSIT = 2'b11;

  localparam logic [1:0] BTN_RUN     = 2'd0;
  localparam logic [1:0] BTN_STEP    = 2'd1;
  localparam logic [1:0] BTN_DEPOSIT = 2'd2;

  // Lowest set index wins; caller guarantees at least one bit is set.
  function automatic logic [1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    if (v[0])      idx = BTN_RUN;
    else if (v[1]) idx = BTN_STEP;
    else           idx = BTN_DEPOSIT;
    return idx;
  endfunction

endpackage

// File: rtl/panel_timeout_counter.sv
// -----------------------------------------------------------------------------
// panel_timeout_counter
//   Load/enable down-counter. Holds at zero; 'expired' is high whenever the
//   count is zero.
// Ports:
//   clock        in   clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   load_i       in   load load_value_i (has priority over enable)
//   enable_i     in   decrement while non-zero
//   load_value_i in   WIDTH-bit reload value
//   expired      out  count has reached zero
// -----------------------------------------------------------------------------
module panel_timeout_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_value_i;
    else if (enable_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/panel_command_sequencer.sv
// -----------------------------------------------------------------------------
// panel_command_sequencer
//   Services wasPressed flags from three panel button detectors, returns a
//   one-cycle one-hot ackPress, and turns each press into one valid/ready
//   command transfer to the CPU control unit. Owns the run/halt mode bit.
//
//   Optional feature macro: PANEL_TIMEOUT_EN
//     defined   : a command left in ISSUE for TIMEOUT_CYCLES cycles without
//                 acceptance is abandoned and sticky timeoutErr is set.
//     undefined : ISSUE waits indefinitely, timeoutErr is tied low.
//
// Ports:
//   clock       in   single clock
//   reset       in   synchronous active-high reset
//   wasPressed  in   [2:0] pressed flags (0 RUN/HALT, 1 STEP, 2 DEPOSIT)
//   switches    in   [DATA_WIDTH-1:0] panel data switches
//   ackPress    out  [2:0] one-hot acknowledge to the serviced detector
//   cmdValid    out  command offered to the CPU
//   cmdCode     out  [1:0] 00 STEP, 01 RUN, 10 HALT, 11 DEPOSIT
//   cmdData     out  [DATA_WIDTH-1:0] latched switches for DEPOSIT, else 0
//   cmdReady    in   CPU accepts the command
//   runMode     out  1 = CPU running
//   timeoutErr  out  sticky: a command was abandoned
// -----------------------------------------------------------------------------
module panel_command_sequencer
  import panel_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BTN-1:0]    wasPressed,
  input  logic [DATA_WIDTH-1:0] switches,
  output logic [NUM_BTN-1:0]    ackPress,
  output logic                  cmdValid,
  output logic [1:0]            cmdCode,
  output logic [DATA_WIDTH-1:0] cmdData,
  input  logic                  cmdReady,
  output logic                  runMode,
  output logic                  timeoutErr
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            code_q, code_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  run_mode_q, run_mode_d;
  logic                  timeout_hit;
  logic                  accept;
  logic [NUM_BTN-1:0]    sel_onehot;

  // Transfer completes on any edge where ISSUE sees cmdReady.
  assign accept = (state_q == ST_ISSUE) && cmdReady;

`ifdef PANEL_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  // Loaded while in ACK so the first ISSUE cycle sees TIMEOUT_CYCLES-1;
  // expiry therefore lands on the TIMEOUT_CYCLES-th ISSUE cycle.
  panel_timeout_counter #(
    .WIDTH (TMR_W)
  ) u_timeout (
    .clock        (clock),
    .reset        (reset),
    .load_i       (state_q == ST_ACK),
    .enable_i     (state_q == ST_ISSUE),
    .load_value_i (TMR_W'(TIMEOUT_CYCLES - 1)),
    .expired      (timeout_hit)
  );

  // Acceptance wins over a coincident timeout.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if ((state_q == ST_ISSUE) && !cmdReady && timeout_hit)
      timeout_err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) timeout_err_q <= 1'b0;
    else       timeout_err_q <= timeout_err_d;
  end

  assign timeoutErr = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeoutErr  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = (|wasPressed) ? ST_ACK : ST_IDLE;
      // A STEP while running is acknowledged but never issued.
      ST_ACK:   state_d = ((sel_q == BTN_STEP) && run_mode_q) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: state_d = (cmdReady || timeout_hit) ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_sel_dec
    assign sel_onehot[gi] = (sel_q == 2'(gi));
  end

  always_comb begin
    ackPress = '0;
    cmdValid = 1'b0;
    case (state_q)
      ST_ACK:   ackPress = sel_onehot;
      ST_ISSUE: cmdValid = 1'b1;
      default: ;
    endcase
  end

  assign cmdCode = code_q;
  assign cmdData = data_q;
  assign runMode = run_mode_q;

  // ---------------------------------------------------------------------------
  // Command latch and run/halt mode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d  = sel_q;
    code_d = code_q;
    data_d = data_q;
    if ((state_q == ST_IDLE) && (|wasPressed)) begin
      sel_d  = lowest_set(wasPressed);
      data_d = '0;
      case (lowest_set(wasPressed))
        BTN_RUN:  code_d = run_mode_q ? CMD_HALT : CMD_RUN;
        BTN_STEP: code_d = CMD_STEP;
        default: begin
          code_d = CMD_DEPOSIT;
          data_d = switches;
        end
      endcase
    end
  end

  always_comb begin
    run_mode_d = run_mode_q;
    if (accept) begin
      if (code_q == CMD_RUN)       run_mode_d = 1'b1;
      else if (code_q == CMD_HALT) run_mode_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q      <= BTN_RUN;
      code_q     <= CMD_STEP;
      data_q     <= '0;
      run_mode_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      code_q     <= code_d;
      data_q     <= data_d;
      run_mode_q <= run_mode_d;
    end
  end

endmodule

// File: tb/tb_panel_command_sequencer.sv
module tb_panel_command_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] wasPressed;
  logic [7:0] switches;
  logic [2:0] ackPress;
  logic       cmdValid;
  logic [1:0] cmdCode;
  logic [7:0] cmdData;
  logic       cmdReady;
  logic       runMode;
  logic       timeoutErr;

  int total = 0;
  int bad   = 0;

`ifdef PANEL_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 5;
`endif

  panel_command_sequencer #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wasPressed (wasPressed),
    .switches   (switches),
    .ackPress   (ackPress),
    .cmdValid   (cmdValid),
    .cmdCode    (cmdCode),
    .cmdData    (cmdData),
    .cmdReady   (cmdReady),
    .runMode    (runMode),
    .timeoutErr (timeoutErr)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    wasPressed = 3'b111;
    switches   = 8'hFF;
    cmdReady   = 1'b0;

    // Reset held 3 cycles with all buttons pressed
    repeat (3) step();
    chk("rst_ack",   ackPress,   3'b000);
    chk("rst_valid", cmdValid,   1'b0);
    chk("rst_code",  cmdCode,    2'b00);
    chk("rst_data",  cmdData,    8'h00);
    chk("rst_run",   runMode,    1'b0);
    chk("rst_terr",  timeoutErr, 1'b0);
    reset = 1'b0;

    // Simultaneous presses: RUN first
    step();
    chk("sim_run_ack",   ackPress, 3'b001);
    chk("sim_run_noval", cmdValid, 1'b0);
    wasPressed = 3'b110;
    cmdReady   = 1'b1;
    switches   = 8'h5A;
    step();
    chk("sim_run_valid", cmdValid, 1'b1);
    chk("sim_run_code",  cmdCode,  2'b01);
    chk("sim_run_ack0",  ackPress, 3'b000);
    chk("sim_run_pre",   runMode,  1'b0);
    step();
    chk("sim_run_done",  cmdValid, 1'b0);
    chk("sim_run_mode",  runMode,  1'b1);
    // STEP acked then dropped because CPU is running
    step();
    chk("sim_step_ack",  ackPress, 3'b010);
    wasPressed = 3'b100;
    step();
    chk("sim_step_drop", cmdValid, 1'b0);
    chk("sim_step_ack0", ackPress, 3'b000);
    // DEPOSIT
    step();
    chk("sim_dep_ack",   ackPress, 3'b100);
    wasPressed = 3'b000;
    step();
    chk("sim_dep_valid", cmdValid, 1'b1);
    chk("sim_dep_code",  cmdCode,  2'b11);
    chk("sim_dep_data",  cmdData,  8'h5A);
    step();
    chk("sim_dep_done",  cmdValid, 1'b0);
    chk("sim_dep_run",   runMode,  1'b1);

    // Data stability: switches change after the latch edge
    cmdReady   = 1'b0;
    switches   = 8'hA5;
    wasPressed = 3'b100;
    step();
    chk("stab_ack", ackPress, 3'b100);
    wasPressed = 3'b000;
    switches   = 8'h3C;
    step();
    chk("stab_valid0", cmdValid, 1'b1);
    chk("stab_data0",  cmdData,  8'hA5);
    for (int i = 0; i < HOLD; i++) begin
      step();
      chk("stab_valid", cmdValid, 1'b1);
      chk("stab_data",  cmdData,  8'hA5);
    end
    cmdReady = 1'b1;
    step();
    chk("stab_done", cmdValid, 1'b0);
    chk("stab_terr", timeoutErr, 1'b0);

    // HALT interrupted by reset
    cmdReady   = 1'b0;
    wasPressed = 3'b001;
    step();
    chk("halt_ack", ackPress, 3'b001);
    wasPressed = 3'b000;
    step();
    chk("halt_valid", cmdValid, 1'b1);
    chk("halt_code",  cmdCode,  2'b10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_rst_valid", cmdValid, 1'b0);
    chk("halt_rst_run",   runMode,  1'b0);
    chk("halt_rst_code",  cmdCode,  2'b00);
    step();
    chk("halt_rst_idle",  cmdValid, 1'b0);
    chk("halt_rst_ack",   ackPress, 3'b000);

    // STEP while halted with cmdReady low
    wasPressed = 3'b010;
    step();
    chk("to_ack", ackPress, 3'b010);
    wasPressed = 3'b000;
    step();
    chk("to_valid0", cmdValid, 1'b1);
    chk("to_code",   cmdCode,  2'b00);
`ifdef PANEL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_valid", cmdValid,   1'b1);
      chk("to_terr0", timeoutErr, 1'b0);
    end
    step();
    chk("to_drop", cmdValid,   1'b0);
    chk("to_terr", timeoutErr, 1'b1);
    chk("to_run",  runMode,    1'b0);
    repeat (2) step();
    chk("to_sticky", timeoutErr, 1'b1);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk("wait_valid", cmdValid,   1'b1);
      chk("wait_terr",  timeoutErr, 1'b0);
    end
    cmdReady = 1'b1;
    step();
    chk("wait_done", cmdValid, 1'b0);
    chk("wait_run",  runMode,  1'b0);
`endif

    // RUN afterwards still works
    cmdReady   = 1'b1;
    wasPressed = 3'b001;
    step();
    chk("run2_ack", ackPress, 3'b001);
    wasPressed = 3'b000;
    step();
    chk("run2_code", cmdCode, 2'b01);
    chk("run2_valid", cmdValid, 1'b1);
    step();
    chk("run2_mode", runMode, 1'b1);
`ifdef PANEL_TIMEOUT_EN
    chk("run2_terr", timeoutErr, 1'b1);
`else
    chk("run2_terr", timeoutErr, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
